round_timer: RTL
================

Name: round_timer

Overview:
Round countdown timer for the fight screen. Counts a 7-bit seconds value down from a programmable start (default 99) to 0 at one step per prescaled tick. Sits directly upstream of the timer BCD converter: time_left feeds that converter's 7-bit binary input, which in turn drives the two-digit timer display. Also signals round expiry to the game-control FSM.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown step (1 s at 50 MHz); legal range 2..2^26.
START_VAL, 99, value loaded on start; legal range 1..99.
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous reset, active-low.
start  input  1  one-cycle pulse: load START_VAL, clear prescaler, enter RUN.
pause  input  1  level: while high, prescaler and count hold.
time_left  output  7  current seconds value, registered, range 0..99.
running  output  1  high in RUN state (including while paused).
expired  output  1  one-cycle pulse on the cycle time_left becomes 0.
done  output  1  level, high in DONE state until next start or reset.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, time_left=START_VAL, prescaler=0, running=0, expired=0, done=0. Reset overrides all other inputs, including mid-count.
- States: IDLE, RUN, DONE. Pause is a qualifier inside RUN, not a separate state.
- IDLE: time_left holds START_VAL. start -> RUN (prescaler=0, time_left=START_VAL).
- RUN, pause=0: prescaler increments each cycle. When prescaler==TICK_DIV-1: prescaler->0 and time_left decrements by 1. The first decrement therefore occurs exactly TICK_DIV cycles after the start pulse.
- RUN, pause=1: prescaler and time_left frozen. Deasserting pause resumes from the frozen prescaler value; there is no prescaler restart.
- Decrement from 1 to 0: on the same edge time_left=0, state=DONE, expired=1 for exactly one cycle, done=1, running=0. time_left never wraps below 0.
- DONE: time_left holds 0; done stays 1; pause ignored. start -> RUN with reload, done=0 on that edge.
- start during RUN, including while paused: reload START_VAL, clear prescaler, stay RUN. This is an immediate restart.
- start and pause high in the same cycle: the reload happens and the state is RUN; pause takes effect from the next cycle, so the count holds.
- start on the same cycle as the final terminal tick: start wins. Reload occurs, expired is not pulsed, and done stays 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Arithmetic: time_left is unsigned 7-bit and decrements only when nonzero; the prescaler compares against TICK_DIV-1 at CNT_W width.

Optional Feature:
Macro TIMER_WARN_EN.
- Defined: adds output port warn (1 bit, registered). warn is high while state=RUN and 1 <= time_left <= 10, low otherwise; it is 0 on reset. The display uses warn to tint the timer digits red.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- TICK_DIV=4, START_VAL=5; reset, then start pulse -> time_left=5 for 4 cycles, then 4,3,2,1,0 every 4 cycles. expired high exactly 1 cycle at the 0 transition; done=1 and running=0 from then on.
- Pause high for 7 cycles mid-RUN at time_left=3, prescaler=2 -> time_left stays 3 throughout. After release, the decrement to 2 occurs 2 cycles later.
- start pulse at time_left=2 -> next cycle time_left=5, prescaler=0, running=1, no expired pulse.
- start asserted on the same cycle as the 1->0 tick -> time_left=5, expired stays 0, done stays 0.
- rst_n low for 1 cycle mid-count at time_left=3 -> time_left=5, state IDLE, running=0, done=0. Counting does not resume without start.
- With TIMER_WARN_EN defined, START_VAL=12, TICK_DIV=2 -> warn rises as time_left reaches 10 and falls as time_left reaches 0 (DONE). Without the macro, the bench compiles without the warn port.

Source files
------------

// File: rtl/round_timer_if.sv
// ============================================================================
// Module      : round_timer_if
// Description : Control/status bundle between game control and round_timer.
//               The warn signal exists only when TIMER_WARN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface round_timer_if;
    logic       start;
    logic       pause;
    logic [6:0] time_left;
    logic       running;
    logic       expired;
    logic       done;
`ifdef TIMER_WARN_EN
    logic       warn;

    modport master (
        output start,
        output pause,
        input  time_left,
        input  running,
        input  expired,
        input  done,
        input  warn
    );

    modport slave (
        input  start,
        input  pause,
        output time_left,
        output running,
        output expired,
        output done,
        output warn
    );
`else
    modport master (
        output start,
        output pause,
        input  time_left,
        input  running,
        input  expired,
        input  done
    );

    modport slave (
        input  start,
        input  pause,
        output time_left,
        output running,
        output expired,
        output done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/round_timer.sv
// ============================================================================
// Module      : round_timer
// Description : Fight-round seconds countdown (START_VAL down to 0, one step
//               per TICK_DIV clocks). Optional macro TIMER_WARN_EN adds warn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int START_VAL = 99,
    parameter int CNT_W     = 26
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    round_timer_if.slave tmr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]       c_START     = 7'(START_VAL);
    localparam logic [6:0]       c_WARN_MAX  = 7'd10;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [6:0]       r_time;
    logic [6:0]       w_time_nxt;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             r_running;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_time    <= c_START;
            r_expired <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_time    <= w_time_nxt;
            r_expired <= w_expired_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_time_nxt    = r_time;
        w_expired_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_presc_nxt = '0;
                w_time_nxt  = c_START;
                if (tmr.start) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // start beats both pause and a coincident terminal tick
                if (tmr.start) begin
                    w_presc_nxt = '0;
                    w_time_nxt  = c_START;
                end else if (!tmr.pause) begin
                    if (r_presc == c_TICK_LAST) begin
                        w_presc_nxt = '0;
                        if (r_time > 7'd1) begin
                            w_time_nxt = r_time - 7'd1;
                        end else begin
                            w_time_nxt    = '0;
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_presc_nxt = '0;
                w_time_nxt  = '0;
                if (tmr.start) begin
                    w_state_nxt = S_RUN;
                    w_time_nxt  = c_START;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_presc_nxt = '0;
                w_time_nxt  = c_START;
            end
        endcase
    end

    assign tmr.time_left = r_time;
    assign tmr.running   = r_running;
    assign tmr.expired   = r_expired;
    assign tmr.done      = r_done;

`ifdef TIMER_WARN_EN
    logic r_warn;
    logic w_warn_nxt;

    // Derived from next-state values so warn lines up with time_left.
    always_comb begin
        w_warn_nxt = (w_state_nxt == S_RUN) && (w_time_nxt != 7'd0) &&
                     (w_time_nxt <= c_WARN_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= w_warn_nxt;
        end
    end

    assign tmr.warn = r_warn;
`endif

endmodule

`default_nettype wire
